// File: rtl/imem_loader.sv
// Program loader: packs a handshaked byte stream into little-endian 32-bit words
// and writes them to sequential memory addresses, holding the core in reset until done.
module imem_loader #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int MAX_WORDS = 1024,
  localparam int LW = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LW-1:0]     len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_write_en_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [LW-1:0] len_reg, word_idx_reg;
  logic [1:0]  byte_cnt_reg;
  logic [23:0] part_reg;

  logic              byte_ready_next, write_en_next, core_rst_next;
  logic              busy_next, done_next, err_next;
  logic [AWIDTH-1:0] mem_addr_next;
  logic [DWIDTH-1:0] mem_data_next;

  logic can_start, last_byte, last_word;
  assign can_start = (state_reg == IDLE) || (state_reg == DONE);
  assign last_byte = (state_reg == LOAD) && byte_valid_i && (byte_cnt_reg == 2'd3);
  assign last_word = (word_idx_reg + LW'(1)) == len_reg;

  // State register plus the registered outputs and load datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      part_reg       <= '0;
      byte_ready_o   <= 1'b0;
      mem_write_en_o <= 1'b0;
      mem_addr_o     <= BASE_ADDR;
      mem_data_o     <= '0;
      core_rst_o     <= 1'b1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_ready_o   <= byte_ready_next;
      mem_write_en_o <= write_en_next;
      mem_addr_o     <= mem_addr_next;
      mem_data_o     <= mem_data_next;
      core_rst_o     <= core_rst_next;
      busy_o         <= busy_next;
      done_o         <= done_next;
      err_o          <= err_next;
      case (state_reg)
        IDLE, DONE: begin
          if (start_i && len_i != '0 && len_i <= MAX_LEN) begin
            len_reg      <= len_i;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
          end
        end
        LOAD: begin
          if (byte_valid_i) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            case (byte_cnt_reg)
              2'd0:    part_reg[7:0]   <= byte_i;
              2'd1:    part_reg[15:8]  <= byte_i;
              2'd2:    part_reg[23:16] <= byte_i;
              default: ;
            endcase
          end
        end
        WRITE: word_idx_reg <= word_idx_reg + LW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          if (len_i == '0)          state_next = DONE;
          else if (len_i > MAX_LEN) state_next = IDLE;
          else                      state_next = LOAD;
        end
      end
      LOAD:  if (last_byte) state_next = WRITE;
      WRITE: state_next = last_word ? DONE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered
  always_comb begin
    byte_ready_next = (state_next == LOAD);
    write_en_next   = (state_next == WRITE);
    busy_next       = (state_next == LOAD) || (state_next == WRITE);
    done_next       = (state_next == DONE);
    core_rst_next   = (state_next != DONE);
    err_next        = err_o;
    mem_addr_next   = mem_addr_o;
    mem_data_next   = mem_data_o;
    if (can_start && start_i) err_next = (len_i > MAX_LEN);
    if (last_byte) begin
      mem_addr_next = BASE_ADDR + (AWIDTH'(word_idx_reg) << 2);
      mem_data_next = {byte_i, part_reg};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued when bytes are
// driven and compared against each observed write strobe.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [10:0] len_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o, mem_write_en_o, core_rst_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [63:0] exp_q[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_en_o(mem_write_en_o),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued write
  always @(negedge clk) begin
    if (!rst && mem_write_en_o) begin
      strobes++;
      check("ready_in_strobe", byte_ready_o, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write", {mem_addr_o, mem_data_o}, e);
        $display("write addr=%h data=%h", mem_addr_o, mem_data_o);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_ready", byte_ready_o, 0);
    check("rst_we", mem_write_en_o, 0);
    check("rst_addr", mem_addr_o, BASE);
    check("rst_data", mem_data_o, 0);
    check("rst_core_rst", core_rst_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
  endtask

  task automatic do_start(input logic [10:0] len);
    @(posedge clk); #1;
    start_i = 1'b1; len_i = len;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Returns 1 ns after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    byte_valid_i = 1'b1; byte_i = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready_o && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("byte_timeout", 1, 0);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap, input logic [31:0] addr);
    exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(maxgap, 0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk); n++;
    end
    check("done_wait", done_o, 1);
  endtask

  initial begin
    int s0;
    logic [31:0] prog[3];
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113; prog[2] = 32'h0020_81B3;

    #12; check_reset_vals();
    @(negedge clk); rst = 1'b0;

    // Single word, back to back
    do_start(11'd1);
    check("start_busy", busy_o, 1);
    check("start_ready", byte_ready_o, 1);
    send_word(32'h0000_0013, 0, BASE);
    check("w1_strobe", mem_write_en_o, 1);
    @(posedge clk); #1;
    check("w1_done", done_o, 1);
    check("w1_core_rst", core_rst_o, 0);
    check("w1_busy", busy_o, 0);

    // Three words with random source gaps
    s0 = strobes;
    do_start(11'd3);
    for (int i = 0; i < 3; i++) send_word(prog[i], 3, BASE + 32'(4 * i));
    wait_done();
    check("w3_strobes", strobes - s0, 3);

    // Illegal then zero length
    s0 = strobes;
    do_start(11'd1025);
    check("ill_err", err_o, 1);
    check("ill_core_rst", core_rst_o, 1);
    check("ill_done", done_o, 0);
    check("ill_busy", busy_o, 0);
    repeat (3) @(posedge clk);
    #1;
    do_start(11'd0);
    check("zero_done", done_o, 1);
    check("zero_err", err_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ill_zero_strobes", strobes - s0, 0);

    // Reset after two bytes of a word
    s0 = strobes;
    do_start(11'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    rst = 1'b1; #1;
    check_reset_vals();
    @(negedge clk); rst = 1'b0;
    check("midrst_strobes", strobes - s0, 0);
    do_start(11'd1);
    send_word(32'hDEAD_BEEF, 2, BASE);
    wait_done();

    // start during LOAD ignored, then restart from DONE
    s0 = strobes;
    do_start(11'd1);
    send_byte(8'h11, 0);
    start_i = 1'b1; len_i = 11'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_q.push_back({BASE, 32'h4433_2211});
    send_byte(8'h22, 0); send_byte(8'h33, 1); send_byte(8'h44, 0);
    wait_done();
    check("ignore_strobes", strobes - s0, 1);
    do_start(11'd1);
    check("restart_core_rst", core_rst_o, 1);
    check("restart_done", done_o, 0);
    send_word(32'h1234_5678, 1, BASE);
    wait_done();

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction words into the shared `memory` block. It is the write-side counterpart to `fetch`, which only reads.
- Accepts a byte stream under a valid/ready handshake and packs each 4 bytes into a little-endian 32-bit word.
- Issues one write per word to sequential addresses starting at `BASE_ADDR`.
- Holds the core in reset until the image is fully loaded.
- Sits between the testbench/host byte source and the memory write port, which the top level currently ties off.

## Interface
- `AWIDTH`, 32, address width of memory write port
- `DWIDTH`, 32, data width; must be 32 (4 bytes per word)
- `BASE_ADDR`, 32'h0100_0000, address of first word written
- `MAX_WORDS`, 1024, largest legal load length in words
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE
- `len_i`  in  $clog2(MAX_WORDS)+1  number of words to load, sampled with `start_i`
- `byte_valid_i`  in  1  byte source has data
- `byte_i`  in  8  byte data
- `byte_ready_o`  out  1  loader accepts byte this cycle
- `mem_addr_o`  out  AWIDTH  write address to memory
- `mem_data_o`  out  DWIDTH  write data to memory
- `mem_write_en_o`  out  1  single-cycle write strobe
- `core_rst_o`  out  1  reset to fetch/decode; high until load completes
- `busy_o`  out  1  load in progress (LOAD or WRITE)
- `done_o`  out  1  load complete
- `err_o`  out  1  sticky; illegal `len_i` on last start

## Operation
- **Outputs:** all registered. A byte transfers when `byte_valid_i && byte_ready_o` at a rising edge.
- **States:**
  - IDLE: waits for `start_i`.
  - LOAD: collects bytes.
  - WRITE: one cycle; strobes the memory write.
  - DONE: image loaded.
- **IDLE/DONE + `start_i`:**
  - `len_i == 0` → DONE; no writes; `err_o` cleared.
  - `len_i > MAX_WORDS` → IDLE; `err_o` set; no writes; `core_rst_o` stays 1.
  - Otherwise → LOAD. Clear the word index and byte count, clear `err_o`, set `core_rst_o` = 1.
- **LOAD:**
  - `byte_ready_o` = 1.
  - Byte k of the current word (k = 0..3) lands in bits [8k+7:8k]; first byte is least significant.
  - When the 4th byte is accepted → WRITE.
- **WRITE:**
  - `mem_write_en_o` = 1, `mem_addr_o` = `BASE_ADDR` + 4×word_index, `mem_data_o` = assembled word.
  - `byte_ready_o` = 0.
  - Then increment word_index (modulo 2^AWIDTH address arithmetic).
  - → DONE if word_index+1 == len, else → LOAD.
- **DONE:**
  - `done_o` = 1, `core_rst_o` = 0, `byte_ready_o` = 0.
  - `mem_addr_o`/`mem_data_o` hold their last values.
- `start_i` in LOAD or WRITE is ignored.
- Bytes presented in IDLE, WRITE or DONE are not accepted (ready = 0).
- `mem_addr_o`/`mem_data_o` are don't-care when `mem_write_en_o` = 0. The implementation holds them stable.

## Timing
- **Reset values:** state IDLE, `byte_ready_o` 0, `mem_write_en_o` 0, `mem_addr_o` `BASE_ADDR`, `mem_data_o` 0, `core_rst_o` 1, `busy_o` 0, `done_o` 0, `err_o` 0.
- **Start:** `start_i` high in cycle N → `busy_o` = 1 and `byte_ready_o` = 1 from cycle N+1.
- **Write:** 4th byte accepted at edge ending cycle M → `mem_write_en_o` high for exactly cycle M+1, with `byte_ready_o` = 0 in M+1.
- **Next word:** `byte_ready_o` returns to 1 in M+2.
- **Last word:** if M+1 was the last write, then from M+2 `done_o` = 1, `core_rst_o` = 0, `busy_o` = 0.
- **Throughput:** with a continuous source, 5 cycles per word (4 accept + 1 write).
- **Backpressure:** `byte_valid_i` low stalls LOAD indefinitely; the partial word is retained.
- **Reset mid-load:** `rst` asserted mid-load returns all outputs to reset values immediately (async). The partial word is discarded; no write is issued. Memory contents already written are unaffected.
- **Restart from DONE:** `core_rst_o` rises in the cycle after `start_i`.

## Test plan
- **Single word:** reset, `start_i` with `len_i` = 1, bytes 0x13,0x00,0x00,0x00 back-to-back → one write, addr 0x0100_0000, data 0x0000_0013. `done_o` = 1 and `core_rst_o` = 0 two cycles after the 4th byte.
- **Three words with gaps:** `len_i` = 3, random `byte_valid_i` gaps, words 0x00500093, 0x00100113, 0x002081B3 → writes at 0x0100_0000, 0x0100_0004, 0x0100_0008 with those data. Exactly 3 strobes; ready = 0 in every strobe cycle.
- **Illegal and zero lengths:**
  - `len_i` = MAX_WORDS+1 → `err_o` = 1, no strobes, `core_rst_o` stays 1.
  - Then `len_i` = 0 → `done_o` = 1, `err_o` = 0, no strobes.
- **Reset mid-load:** assert `rst` after 2 bytes of word 1 → no strobe, all outputs at reset values.
  - Then load 1 word 0xDEADBEEF (bytes EF,BE,AD,DE) → addr 0x0100_0000, data 0xDEADBEEF.
- **Start ignored while busy:** `start_i` pulsed during LOAD → no effect.
  - After DONE, `start_i` with `len_i` = 1 → `core_rst_o` back to 1 next cycle, `done_o` = 0.
  - The new word writes to 0x0100_0000.
